// File: rtl/csr_cfg_master.sv
// Avalon-MM initiator that programs and read-back-verifies the ingress width-adjuster CSRs
// (scratch 0x0, control 0x4, thresholds 0x8) on a start pulse, with sticky done/error capture.
module csr_cfg_master #(
  parameter logic [31:0] SCRATCH_PATTERN = 32'hA5C3_5A3C,
  parameter int unsigned TIMEOUT         = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        cfg_rx_pause_en,
  input  logic [15:0] cfg_rx_pause_threshold,
  input  logic [15:0] cfg_drop_threshold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  err_addr,
  output logic [31:0] err_rdata,
  output logic [3:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);
  typedef enum logic [2:0] {IDLE, CMD, RWAIT, DONE, ERR} state_t;

  localparam logic [2:0] LAST_STEP = 3'd5;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        en_q, en_d;
  logic [15:0] pause_q, pause_d, drop_q, drop_d;
  logic        done_q, done_d, error_q, error_d;
  logic [1:0]  code_q, code_d;
  logic [3:0]  eaddr_q, eaddr_d;
  logic [31:0] erdata_q, erdata_d;

  // Per-step command; s_data is the write data for writes and the expected value for reads.
  logic [3:0]  s_addr;
  logic        s_read;
  logic [31:0] s_data;
  logic [3:0]  s_be;

  always_comb begin
    s_addr = 4'h0;
    s_read = 1'b0;
    s_data = SCRATCH_PATTERN;
    s_be   = 4'hF;
    case (step_q)
      3'd0: s_read = 1'b0;
      3'd1: s_read = 1'b1;
      3'd2: begin s_addr = 4'h4; s_data = {31'b0, en_q}; s_be = 4'h1; end
      3'd3: begin s_addr = 4'h8; s_data = {drop_q, pause_q}; end
      3'd4: begin s_addr = 4'h4; s_read = 1'b1; s_data = {31'b0, en_q}; end
      default: begin s_addr = 4'h8; s_read = 1'b1; s_data = {drop_q, pause_q}; end
    endcase
  end

  logic        adv, fail;
  logic [1:0]  fail_code;
  logic [31:0] fail_rdata;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    wcnt_d     = wcnt_q;
    en_d       = en_q;
    pause_d    = pause_q;
    drop_d     = drop_q;
    done_d     = done_q;
    error_d    = error_q;
    code_d     = code_q;
    eaddr_d    = eaddr_q;
    erdata_d   = erdata_q;
    adv        = 1'b0;
    fail       = 1'b0;
    fail_code  = 2'b00;
    fail_rdata = 32'h0;
    case (state_q)
      CMD: begin
        if (avm_readdatavalid) begin
          fail = 1'b1; fail_code = 2'b11;
        end else if (!avm_waitrequest) begin
          if (s_read) begin
            state_d = RWAIT;
            wcnt_d  = 8'd0;
          end else begin
            adv = 1'b1;
          end
        end
      end
      RWAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        // A response in the last allowed cycle still counts as on time.
        if (avm_readdatavalid) begin
          if (avm_readdata == s_data) adv = 1'b1;
          else begin
            fail = 1'b1; fail_code = 2'b01; fail_rdata = avm_readdata;
          end
        end else if (wcnt_q == WAIT_LAST) begin
          fail = 1'b1; fail_code = 2'b10;
        end
      end
      default: begin
        if (start) begin
          state_d  = CMD;
          step_d   = 3'd0;
          en_d     = cfg_rx_pause_en;
          pause_d  = cfg_rx_pause_threshold;
          drop_d   = cfg_drop_threshold;
          done_d   = 1'b0;
          error_d  = 1'b0;
          code_d   = 2'b00;
          eaddr_d  = 4'h0;
          erdata_d = 32'h0;
        end
      end
    endcase
    if (adv) begin
      if (step_q == LAST_STEP) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = CMD;
        step_d  = step_q + 3'd1;
      end
    end
    if (fail) begin
      state_d  = ERR;
      error_d  = 1'b1;
      code_d   = fail_code;
      eaddr_d  = s_addr;
      erdata_d = fail_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      step_q   <= 3'd0;
      wcnt_q   <= 8'd0;
      en_q     <= 1'b0;
      pause_q  <= 16'h0;
      drop_q   <= 16'h0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= 2'b00;
      eaddr_q  <= 4'h0;
      erdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      wcnt_q   <= wcnt_d;
      en_q     <= en_d;
      pause_q  <= pause_d;
      drop_q   <= drop_d;
      done_q   <= done_d;
      error_q  <= error_d;
      code_q   <= code_d;
      eaddr_q  <= eaddr_d;
      erdata_q <= erdata_d;
    end
  end

  assign busy           = (state_q == CMD) || (state_q == RWAIT);
  assign done           = done_q;
  assign error          = error_q;
  assign err_code       = code_q;
  assign err_addr       = eaddr_q;
  assign err_rdata      = erdata_q;
  assign avm_write      = (state_q == CMD) && !s_read;
  assign avm_read       = (state_q == CMD) && s_read;
  assign avm_address    = (state_q == CMD) ? s_addr : 4'h0;
  assign avm_writedata  = avm_write ? s_data : 32'h0;
  assign avm_byteenable = (state_q == CMD) ? s_be : 4'h0;
endmodule

// File: doc/csr_cfg_master.md
Name: csr_cfg_master

Overview:
- Avalon-MM initiator that programs and verifies the ingress width-adjuster CSR block: scratch, control (0x4), thresholds (0x8).
- On a `start` pulse it runs a fixed sequence:
  - scratch write, then read-back;
  - control write and threshold write;
  - read-back compare of both.
- Sits between the port bring-up controller and the CSR responder.
- Reports done or error with diagnostic capture.

Parameters:
- SCRATCH_PATTERN, 32'hA5C3_5A3C, value written to and expected from scratch (0x0).
- TIMEOUT, 16, max cycles to wait for readdatavalid after a read is accepted (legal range 2..255).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run the sequence
- cfg_rx_pause_en  in  1  value for control bit0
- cfg_rx_pause_threshold  in  16  value for 0x8[15:0]
- cfg_drop_threshold  in  16  value for 0x8[31:16]
- busy  out  1  sequence in progress
- done  out  1  sticky, sequence completed clean
- error  out  1  sticky, sequence aborted
- err_code  out  2  01 mismatch, 10 timeout, 11 spurious readdatavalid
- err_addr  out  4  address of the failing access
- err_rdata  out  32  readdata captured at mismatch (0 otherwise)
- avm_address  out  4  byte address
- avm_write  out  1  write command
- avm_read  out  1  read command
- avm_writedata  out  32  write data
- avm_byteenable  out  4  byte enables
- avm_waitrequest  in  1  responder stall (tie 0 for the CSR block)
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous, active-low `reset_n`.
- Reset values: all outputs 0; state IDLE.
- Reset mid-sequence: the current command is dropped immediately. The responder is not guaranteed a completion.
- Start handling:
  - `start` is sampled only in IDLE, DONE or ERR; it is ignored while busy.
  - On acceptance, the three cfg inputs are latched and done, error, err_* are cleared.
  - busy=1 from the next cycle.
- States: IDLE, CMD, RWAIT, DONE, ERR, plus step index 0..5.
- Steps (address / operation / data / byteenable):
  - 0: 0x0 / write / SCRATCH_PATTERN / F
  - 1: 0x0 / read / expect SCRATCH_PATTERN
  - 2: 0x4 / write / {31'b0, en} / 1
  - 3: 0x8 / write / {drop, pause} / F
  - 4: 0x4 / read / expect {31'b0, en}
  - 5: 0x8 / read / expect {drop, pause}
- CMD state:
  - Exactly one of avm_write/avm_read is high. address, writedata and byteenable are stable while avm_waitrequest=1.
  - The command is accepted on the first cycle with waitrequest=0.
  - Write accepted: next step, or DONE after step 5.
  - Read accepted: go to RWAIT; avm_read drops the next cycle.
  - Read byteenable = F.
- Read response (RWAIT):
  - Wait counter starts at 0 and increments each RWAIT cycle.
  - On readdatavalid, compare all 32 bits:
    - equal: next step in CMD the following cycle;
    - unequal: ERR, err_code=01, err_addr, err_rdata=readdata.
  - If the counter reaches TIMEOUT with no readdatavalid: ERR, err_code=10.
  - readdatavalid and timeout in the same cycle: readdatavalid wins.
- Spurious readdatavalid: valid arriving outside RWAIT while busy gives ERR, code 11, err_addr = current step address. It is ignored in IDLE, DONE and ERR.
- Terminal states:
  - DONE: done=1, busy=0.
  - ERR: error=1, busy=0, no further commands.
  - Both hold until the next accepted start.
- Latency with waitrequest=0 and 1-cycle read latency, start sampled at cycle 0:
  - cmds at cycles 1,2,4,5,6,8;
  - readdatavalid at 3,7,9;
  - done=1 at cycle 10.
- avm_write and avm_read are never high simultaneously, and never high outside CMD.

Test Plan:
1. Nominal, responder attached:
   - Stimulus: en=1, pause=16'h0400, drop=16'h0C00, start.
   - Response: 0x4=1, 0x8=32'h0C00_0400; done at cycle 10; error=0; exactly 6 commands.
2. Waitrequest stall: hold avm_waitrequest=1 for 3 cycles on step 3 → address 0x8, writedata and byteenable F stable all 4 cycles; done at cycle 13.
3. Mismatch: responder returns 32'h0C00_0401 on step 5 → error=1, err_code=01, err_addr=0x8, err_rdata=32'h0C00_0401, done=0.
4. Timeout: suppress readdatavalid on step 1 with TIMEOUT=16 → error with code 10 and err_addr=0x0 after 16 RWAIT cycles; no further commands.
5. Control cases:
   - start pulsed while busy is ignored; the sequence completes unchanged.
   - A spurious readdatavalid during step 2 → err_code=11, err_addr=0x4.
6. Reset and restart: drop reset_n during step 3 → all outputs 0 asynchronously. A new start after release runs the full sequence to done.
